seven_segment_scan: RTL and testbench
=====================================

Name: seven_segment_scan

Overview:
Parametrised multiplexed seven-segment display driver that scans NUM_DIGITS common-cathode digits from one packed hex word. It adds several features: frame-synchronous (tear-free) input latching, per-digit decimal points, leading-zero blanking, 16-level PWM brightness and a frame strobe. It sits at the board I/O boundary and displays CPU register/bus values.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8).
SCAN_DIV, 65536, clk cycles per digit slot; must be a power of two and at least 16.

Ports:
clk  input  1  system clock; all state is on its rising edge.
rst_n  input  1  asynchronous active-low reset.
din  input  4*NUM_DIGITS  hex value; the top nibble is digit 0 (leftmost).
dp_in  input  NUM_DIGITS  decimal-point request; bit k belongs to digit k.
blank_lz  input  1  1 = suppress leading zero digits.
brightness  input  4  PWM level; 15 = full on, 0 = 1/16 duty.
enable  input  1  0 = display dark; scanning continues.
grounds  output  NUM_DIGITS  digit selects, active-low; bit k low = digit k lit.
display  output  7  segments, active-high; bit6=a … bit0=g.
dp  output  1  decimal-point segment, active-high.
frame_tick  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Prescaler p, width log2(SCAN_DIV):
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick is asserted when p == SCAN_DIV-1.
- Digit index idx, range 0..NUM_DIGITS-1:
  - Increments on tick.
  - Wraps from NUM_DIGITS-1 to 0; this wrap is the frame boundary.
- Frame boundary actions, all in the same edge:
  - Shadow registers capture din, dp_in, brightness and blank_lz.
  - frame_tick = 1 for that single cycle.
  - The inputs are ignored at all other times; a mid-frame change of din never alters the frame being shown.
- Reset (async, rst_n low):
  - p=0, idx=NUM_DIGITS-1, shadows=0.
  - grounds=all ones, display=0, dp=0, frame_tick=0.
  - The first frame boundary is therefore SCAN_DIV cycles after reset release; outputs stay dark until then.
  - Reset asserted mid-scan returns to this state immediately.
- Segment decode, shadow nibble of digit idx:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Leading-zero blanking (shadow blank_lz=1):
  - Digit k is blanked if it and every digit with lower index are 0.
  - Digit NUM_DIGITS-1 (rightmost) is never blanked, so value 0 shows a single "0".
  - A blanked digit's dp is still shown if requested; its segments are 0.
- PWM:
  - phase = top 4 bits of p.
  - Digit is lit only when phase <= shadow brightness.
  - Duty = (brightness+1)/16 of each slot.
- Lit condition:
  - enable=1, PWM phase on, and digit not fully blank (segments nonzero or dp requested).
  - When lit: grounds = all ones except bit idx = 0; display = decoded segments (0 if blanked); dp = shadow dp_in[idx].
  - When not lit: grounds = all ones, display=0, dp=0.
- Output timing:
  - All outputs are registered; they reflect p/idx/shadow state with 1 cycle latency.
  - At most one grounds bit is low in any cycle.
- enable:
  - Sampled every cycle and not shadowed.
  - Deasserting it darkens the outputs on the next edge.
  - p, idx and the shadows keep running, so re-enable resumes in phase.
- Simultaneous events: input changes coinciding with the frame boundary edge are captured; reset overrides everything.

Test Plan:
- Reset/first frame (SCAN_DIV=16, NUM_DIGITS=4, din=16'h12AF, brightness=15, enable=1): release rst_n.
  - grounds=1111 for 16 cycles.
  - frame_tick pulses once.
  - Then grounds=1110 with display=0110000 for 16 cycles, followed by 1101/1101101, 1011/1110111, 0111/1000111.
  - Sequence repeats every 64 cycles.
- Tear-free latch: change din 16'h1234→16'h5678 in mid-frame.
  - Remainder of the frame still shows 3,4.
  - From the next frame_tick, the 5,6,7,8 patterns appear.
- Leading-zero blanking: din=16'h0040, blank_lz=1.
  - Digits 0,1 keep grounds=1111 during their slots.
  - Digit 2 shows 0110011; digit 3 shows 1111110.
  - din=0 shows only digit 3 "0".
- Brightness: brightness=3.
  - Each digit's ground is low for exactly 4 of every 16 slot cycles (phases 0..3), with 4:16 duty.
  - brightness=0 gives 1 of 16.
- Decimal points and enable: dp_in=4'b0100.
  - dp=1 only during digit 2's lit cycles.
  - Dropping enable mid-slot gives grounds=1111, display=0, dp=0 on the next edge.
  - Re-raising enable resumes at the same idx/p as an uninterrupted scan.
- Async reset mid-scan: assert rst_n=0 between clock edges.
  - Outputs go dark immediately, without waiting for a clock edge.
  - After release, the sequence restarts exactly as in the first scenario.

Source files
------------

// File: rtl/seven_segment_scan.sv
// Multiplexed common-cathode seven-segment scanner with frame-synchronous input
// latching, leading-zero blanking, decimal points and 16-level PWM brightness.
module seven_segment_scan #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 65536
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [3:0]              brightness,
    input  logic                    enable,
    output logic [NUM_DIGITS-1:0]   grounds,
    output logic [6:0]              display,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         p;
    logic [IW-1:0]         idx;
    logic [3:0]            digit_sh [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_sh;
    logic [3:0]            bright_sh;
    logic                  blank_sh;
    logic                  loaded;

    logic                  tick;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  zero_run;
    logic [6:0]            seg;
    logic                  dp_bit;
    logic [3:0]            phase;
    logic                  lit;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'b1111110;
            4'h1: decode = 7'b0110000;
            4'h2: decode = 7'b1101101;
            4'h3: decode = 7'b1111001;
            4'h4: decode = 7'b0110011;
            4'h5: decode = 7'b1011011;
            4'h6: decode = 7'b1011111;
            4'h7: decode = 7'b1110000;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1111011;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b0011111;
            4'hC: decode = 7'b1001110;
            4'hD: decode = 7'b0111101;
            4'hE: decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

    assign tick      = (p == '1);
    assign frame_end = tick && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            idx       <= LAST_IDX;
            dp_sh     <= '0;
            bright_sh <= '0;
            blank_sh  <= 1'b0;
            loaded    <= 1'b0;
            for (int unsigned k = 0; k < NUM_DIGITS; k++) digit_sh[k] <= '0;
        end else begin
            p <= p + 1'b1;
            if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (frame_end) begin
                for (int unsigned k = 0; k < NUM_DIGITS; k++)
                    digit_sh[k] <= din[4*(NUM_DIGITS-1-k) +: 4];
                dp_sh     <= dp_in;
                bright_sh <= brightness;
                blank_sh  <= blank_lz;
                loaded    <= 1'b1;
            end
        end
    end

    // Blanking runs left to right while digits stay zero; the rightmost digit always shows.
    always_comb begin
        blank_vec = '0;
        zero_run  = blank_sh;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_run     = zero_run && (digit_sh[k] == 4'h0);
            blank_vec[k] = zero_run && (k != NUM_DIGITS - 1);
        end
    end

    always_comb begin
        phase  = p[PW-1 -: 4];
        seg    = blank_vec[idx] ? 7'b0 : decode(digit_sh[idx]);
        dp_bit = dp_sh[idx];
        lit    = enable && loaded && (phase <= bright_sh) && ((seg != 7'b0) || dp_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grounds    <= '1;
            display    <= '0;
            dp         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (lit) begin
                grounds <= ~(NUM_DIGITS'(1) << idx);
                display <= seg;
                dp      <= dp_bit;
            end else begin
                grounds <= '1;
                display <= '0;
                dp      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan (4 digits, 16-cycle slots) against a
// cycle-count based reference model.
module tb_seven_segment_scan;

    localparam int unsigned ND  = 4;
    localparam int unsigned DIV = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   din;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [3:0]    brightness;
    logic          enable;
    logic [3:0]    grounds;
    logic [6:0]    display;
    logic          dp;
    logic          frame_tick;

    int unsigned   errors = 0;
    int unsigned   checks = 0;

    // Model state: edges since reset release and the inputs latched at the last frame boundary.
    int unsigned   t;
    logic [15:0]   rec_din;
    logic [3:0]    rec_dp;
    logic [3:0]    rec_bright;
    logic          rec_blz;

    logic [6:0]    seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    seven_segment_scan #(.NUM_DIGITS(ND), .SCAN_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .enable     (enable),
        .grounds    (grounds),
        .display    (display),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int unsigned ph, ix, shifted;
        logic        boundary, blanked, dpb, lit;
        logic [6:0]  seg;
        logic [3:0]  exp_g;
        ph       = t % DIV;
        ix       = (ND - 1 + t / DIV) % ND;
        boundary = (ph == DIV - 1) && (ix == ND - 1);
        shifted  = 32'(rec_din) >> (4 * (ND - 1 - ix));
        blanked  = rec_blz && (shifted == 0) && (ix < ND - 1);
        seg      = blanked ? 7'b0 : seg_tab[shifted % 16];
        dpb      = rec_dp[ix];
        lit      = enable && (t >= DIV) && (ph <= rec_bright) && ((seg != 7'b0) || dpb);
        exp_g    = lit ? (4'hF & ~(4'h1 << ix)) : 4'hF;
        if (boundary) begin
            rec_din    = din;
            rec_dp     = dp_in;
            rec_bright = brightness;
            rec_blz    = blank_lz;
        end
        @(posedge clk);
        #1;
        t++;
        chk("grounds", 32'(grounds), 32'(exp_g));
        chk("display", 32'(display), lit ? 32'(seg) : 0);
        chk("dp", 32'(dp), lit ? 32'(dpb) : 0);
        chk("frame_tick", 32'(frame_tick), 32'(boundary));
        chk("one_hot_ground", $countones(~grounds) <= 1 ? 1 : 0, 1);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        t          = 0;
        rec_din    = '0;
        rec_dp     = '0;
        rec_bright = '0;
        rec_blz    = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 16'h12AF;
        dp_in      = 4'b0000;
        blank_lz   = 1'b0;
        brightness = 4'd15;
        enable     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_grounds", 32'(grounds), 32'hF);
        chk("reset_display", 32'(display), 0);
        chk("reset_dp", 32'(dp), 0);
        chk("reset_frame_tick", 32'(frame_tick), 0);

        // first frame and steady repeating scan
        release_reset();
        run(16 + 64 * 2);

        // tear-free latch: 1234 captured, then changed mid-frame
        din = 16'h1234;
        run(64);
        run(40);
        din = 16'h5678;
        run(24 + 64);

        // leading-zero blanking
        blank_lz = 1'b1;
        din      = 16'h0040;
        run(128);
        din = 16'h0000;
        run(128);
        blank_lz = 1'b0;

        // brightness levels
        din        = 16'h9BCD;
        brightness = 4'd3;
        run(128);
        brightness = 4'd0;
        run(128);
        brightness = 4'd15;

        // decimal points and enable dropped mid-slot
        dp_in = 4'b0100;
        run(64 + 70);
        enable = 1'b0;
        run(37);
        enable = 1'b1;
        run(80);

        // blanked digit with a requested decimal point
        din      = 16'h0005;
        dp_in    = 4'b1010;
        blank_lz = 1'b1;
        run(128);

        // randomized inputs at random points in the scan
        for (int i = 0; i < 60; i++) begin
            din        = 16'($urandom);
            dp_in      = 4'($urandom);
            blank_lz   = 1'($urandom);
            brightness = 4'($urandom);
            enable     = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) din[15:8] = 8'h00;
            run($urandom_range(1, 90));
        end
        enable = 1'b1;

        // async reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_grounds", 32'(grounds), 32'hF);
        chk("async_display", 32'(display), 0);
        chk("async_dp", 32'(dp), 0);
        chk("async_frame_tick", 32'(frame_tick), 0);
        repeat (2) @(posedge clk);
        din        = 16'h12AF;
        dp_in      = 4'b0000;
        blank_lz   = 1'b0;
        brightness = 4'd15;
        release_reset();
        run(16 + 64 * 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
